if_spi_mc: RTL and testbench

Parametrised byte-stream-to-SPI master bridge, successor to the single-channel byte-FIFO SPI interface. Packs incoming bytes into D_WIDTH-bit words, transmits each word on an internal SPI engine with run-time CPOL/CPHA, clock divider, chip-select selection and optional CS hold for bursts. Received words are unpacked to bytes and queued for the host-side command/readback logic.

---
 rtl/if_spi_mc.sv | 237 +++++++++++++++++++++++
 tb/tb_if_spi_mc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_spi_mc.sv
// Byte-stream to SPI master bridge: packs host bytes into words, shifts them
// out on a mode/divider-configurable SPI engine and unpacks received words
// back into a byte stream for the host.
module if_spi_mc #(
    parameter int unsigned D_WIDTH  = 16,
    parameter int unsigned NUM_CS   = 2,
    parameter int unsigned TX_DEPTH = 32,
    parameter int unsigned RX_DEPTH = 32,
    parameter int unsigned DIV_W    = 4,
    localparam int unsigned BYTES   = D_WIDTH / 8,
    localparam int unsigned CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int unsigned LEN_W   = $clog2(RX_DEPTH * BYTES) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              hold_cs,
    output logic [NUM_CS-1:0] cs,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    input  logic [7:0]        in_data,
    input  logic              in_ena,
    output logic              in_ready,
    input  logic              rd_req,
    output logic [7:0]        out_data,
    output logic              have_msg,
    output logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              tx_overflow,
    output logic              rx_overflow
);

    localparam int unsigned TX_AW   = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW   = TX_AW + 1;
    localparam int unsigned RX_AW   = $clog2(RX_DEPTH);
    localparam int unsigned RX_CW   = RX_AW + 1;
    localparam int unsigned BC_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned EC_W    = $clog2(2 * D_WIDTH) + 1;
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(2 * D_WIDTH);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, LAG, GAP} state_t;

    state_t               state;
    logic [D_WIDTH-1:0]   pk_word;
    logic [BC_W-1:0]      pk_cnt;
    logic [D_WIDTH-1:0]   tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]     tx_wp, tx_rp;
    logic [TX_CW-1:0]     tx_cnt;
    logic [D_WIDTH-1:0]   rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]     rx_wp, rx_rp;
    logic [RX_CW-1:0]     rx_cnt;
    logic [BC_W-1:0]      rx_bidx;
    logic                 cpha_r;
    logic [DIV_W-1:0]     d_r;
    logic [DIV_W-1:0]     div_cnt;
    logic [EC_W-1:0]      edge_cnt;
    logic [D_WIDTH-1:0]   tx_sr, rx_sr;

    logic [D_WIDTH-1:0]   pk_next_c, tx_head_c, rx_head_c;
    logic                 pk_last_c, tx_full_c, tx_empty_c, tx_wr_c, tx_pop_c;
    logic                 rx_full_c, rx_push_c, rx_wr_c, rd_ok_c, rx_pop_c;
    logic [TX_CW-1:0]     tx_cnt_nxt_c;
    logic [LEN_W-1:0]     len_nxt_c;
    logic [DIV_W-1:0]     d_c;
    logic                 div_last_c, edge_c, sample_c, shift_c;
    logic [NUM_CS-1:0]    cs_on_c;
    int unsigned          rx_sh_c;

    // Datapath glue: packer, FIFO status, engine edge decode, RX byte select
    always_comb begin
        pk_next_c    = (pk_word << 8) | D_WIDTH'(in_data);
        pk_last_c    = in_ena && (pk_cnt == BC_W'(BYTES - 1));
        tx_full_c    = (tx_cnt == TX_CW'(TX_DEPTH));
        tx_empty_c   = (tx_cnt == '0);
        tx_wr_c      = pk_last_c && !tx_full_c;
        tx_head_c    = tx_mem[tx_rp];
        d_c          = (clk_div == '0) ? DIV_W'(1) : clk_div;
        div_last_c   = (div_cnt == d_r - DIV_W'(1));
        tx_pop_c     = !tx_empty_c &&
                       ((state == IDLE) || ((state == LAG) && div_last_c && hold_cs));
        tx_cnt_nxt_c = tx_cnt + TX_CW'(tx_wr_c) - TX_CW'(tx_pop_c);
        edge_c       = div_last_c &&
                       ((state == LEAD) || ((state == SHIFT) && (edge_cnt != EC_LAST)));
        // next edge number is edge_cnt+1; odd edges sample when cpha=0
        sample_c     = edge_c && (!edge_cnt[0] ^ cpha_r);
        shift_c      = edge_c && !(!edge_cnt[0] ^ cpha_r);
        rx_push_c    = (state == SHIFT) && div_last_c && (edge_cnt == EC_LAST);
        rx_full_c    = (rx_cnt == RX_CW'(RX_DEPTH));
        rx_wr_c      = rx_push_c && !rx_full_c;
        rd_ok_c      = rd_req && (len != '0);
        rx_pop_c     = rd_ok_c && (rx_bidx == BC_W'(BYTES - 1));
        rx_head_c    = rx_mem[rx_rp];
        rx_sh_c      = 8 * (BYTES - 1 - 32'(rx_bidx));
        len_nxt_c    = len + (rx_wr_c ? LEN_W'(BYTES) : LEN_W'(0)) - LEN_W'(rd_ok_c);
        cs_on_c      = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (32'(cs_sel) == i) cs_on_c[i] = 1'b0;
        end
    end

    // Word storage for both FIFOs (not reset)
    always_ff @(posedge clk) begin
        if (tx_wr_c) tx_mem[tx_wp] <= pk_next_c;
        if (rx_wr_c) rx_mem[rx_wp] <= rx_sr;
    end

    // Byte packer and TX FIFO pointers/flags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pk_word     <= '0;
            pk_cnt      <= '0;
            tx_wp       <= '0;
            tx_rp       <= '0;
            tx_cnt      <= '0;
            tx_overflow <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            if (in_ena) begin
                pk_word <= pk_next_c;
                pk_cnt  <= pk_last_c ? '0 : pk_cnt + BC_W'(1);
            end
            if (pk_last_c && tx_full_c) tx_overflow <= 1'b1;
            if (tx_wr_c)  tx_wp <= tx_wp + TX_AW'(1);
            if (tx_pop_c) tx_rp <= tx_rp + TX_AW'(1);
            tx_cnt   <= tx_cnt_nxt_c;
            in_ready <= (tx_cnt_nxt_c != TX_CW'(TX_DEPTH));
        end
    end

    // SPI engine: IDLE -> LEAD -> SHIFT -> LAG -> (LEAD if CS held | GAP) -> IDLE
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            cs       <= '1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            cpha_r   <= 1'b0;
            d_r      <= DIV_W'(1);
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            case (state)
                IDLE: sclk <= cpol;
                LEAD, SHIFT: begin
                    if (div_last_c) begin
                        div_cnt <= '0;
                        if ((state == SHIFT) && (edge_cnt == EC_LAST)) begin
                            state <= LAG;
                        end else begin
                            state    <= SHIFT;
                            edge_cnt <= edge_cnt + EC_W'(1);
                            sclk     <= ~sclk;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                LAG: begin
                    if (div_last_c) begin
                        div_cnt <= '0;
                        if (!tx_pop_c) begin
                            cs    <= '1;
                            state <= GAP;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (div_last_c) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (sample_c) rx_sr <= {rx_sr[D_WIDTH-2:0], miso};
            if (shift_c) begin
                mosi  <= tx_sr[D_WIDTH-1];
                tx_sr <= tx_sr << 1;
            end
            // word start: relatch mode/divider; cs only chosen when leaving IDLE
            if (tx_pop_c) begin
                state    <= LEAD;
                busy     <= 1'b1;
                cpha_r   <= cpha;
                d_r      <= d_c;
                div_cnt  <= '0;
                edge_cnt <= '0;
                sclk     <= cpol;
                if (state == IDLE) cs <= cs_on_c;
                if (!cpha) begin
                    mosi  <= tx_head_c[D_WIDTH-1];
                    tx_sr <= tx_head_c << 1;
                end else begin
                    tx_sr <= tx_head_c;
                end
            end
        end
    end

    // RX FIFO and MSB-first byte unpacker
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_wp       <= '0;
            rx_rp       <= '0;
            rx_cnt      <= '0;
            rx_bidx     <= '0;
            rx_overflow <= 1'b0;
            out_data    <= '0;
            len         <= '0;
            have_msg    <= 1'b0;
        end else begin
            if (rx_push_c && rx_full_c) rx_overflow <= 1'b1;
            if (rx_wr_c) rx_wp <= rx_wp + RX_AW'(1);
            if (rd_ok_c) begin
                out_data <= 8'(rx_head_c >> rx_sh_c);
                rx_bidx  <= rx_pop_c ? '0 : rx_bidx + BC_W'(1);
            end
            if (rx_pop_c) rx_rp <= rx_rp + RX_AW'(1);
            rx_cnt   <= rx_cnt + RX_CW'(rx_wr_c) - RX_CW'(rx_pop_c);
            len      <= len_nxt_c;
            have_msg <= (len_nxt_c != '0);
        end
    end

endmodule

// File: tb/tb_if_spi_mc.sv
// Scoreboarded bench for if_spi_mc with MISO looped back to MOSI.
module tb_if_spi_mc;

    localparam int unsigned D_WIDTH  = 16;
    localparam int unsigned NUM_CS   = 3;
    localparam int unsigned TX_DEPTH = 4;
    localparam int unsigned RX_DEPTH = 4;
    localparam int unsigned DIV_W    = 4;
    localparam int unsigned CS_W     = $clog2(NUM_CS);
    localparam int unsigned LEN_W    = $clog2(RX_DEPTH * (D_WIDTH / 8)) + 1;

    logic              clk, n_rst, cpol, cpha, hold_cs, miso, in_ena, in_ready, rd_req;
    logic [DIV_W-1:0]  clk_div;
    logic [CS_W-1:0]   cs_sel;
    logic [NUM_CS-1:0] cs;
    logic              sclk, mosi, have_msg, busy, tx_overflow, rx_overflow;
    logic [7:0]        in_data, out_data;
    logic [LEN_W-1:0]  len;

    if_spi_mc #(.D_WIDTH(D_WIDTH), .NUM_CS(NUM_CS), .TX_DEPTH(TX_DEPTH),
                .RX_DEPTH(RX_DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .n_rst(n_rst), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
        .cs_sel(cs_sel), .hold_cs(hold_cs), .cs(cs), .sclk(sclk), .mosi(mosi),
        .miso(miso), .in_data(in_data), .in_ena(in_ena), .in_ready(in_ready),
        .rd_req(rd_req), .out_data(out_data), .have_msg(have_msg), .len(len),
        .busy(busy), .tx_overflow(tx_overflow), .rx_overflow(rx_overflow));

    assign miso = mosi;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a byte is presented the cycle after an accepted rd_req
    always @(posedge clk) begin
        bit v;
        v = rd_req && have_msg && n_rst;
        #1;
        if (v) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: got %0h expected no byte", out_data);
            end else begin
                check("rx_byte", out_data, exp_q.pop_front());
            end
        end
    end

    // Physical-layer monitor
    bit          mon_clr;
    int          rises, samp_n, busy_cyc, cs1_cur, cs1_pulses, cs1_min, cs1_max, hi_cur, gap_min;
    bit          other_low;
    logic [15:0] mosi_cap;
    logic        prev_sclk, prev_cs1;

    always @(posedge clk) begin
        #1;
        if (mon_clr) begin
            rises = 0; samp_n = 0; busy_cyc = 0; cs1_cur = 0; cs1_pulses = 0;
            cs1_min = 1000000; cs1_max = 0; hi_cur = 0; gap_min = 1000000;
            other_low = 0; mosi_cap = '0;
        end else begin
            if (busy) busy_cyc++;
            if (busy && (sclk != prev_sclk)) begin
                if (sclk) rises++;
                if (sclk == (cpol == cpha)) begin
                    mosi_cap = {mosi_cap[14:0], mosi};
                    samp_n++;
                end
            end
            if (!cs[0] || !cs[2]) other_low = 1;
            if (!cs[1]) begin
                if (prev_cs1 && (cs1_pulses > 0) && (hi_cur < gap_min)) gap_min = hi_cur;
                cs1_cur++;
            end else begin
                if (!prev_cs1) begin
                    cs1_pulses++;
                    if (cs1_cur < cs1_min) cs1_min = cs1_cur;
                    if (cs1_cur > cs1_max) cs1_max = cs1_cur;
                    cs1_cur = 0;
                    hi_cur  = 0;
                end
                hi_cur++;
            end
        end
        prev_sclk = sclk;
        prev_cs1  = cs[1];
    end

    task automatic clr_mon();
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit expect_rx);
        @(negedge clk); in_ena = 1'b1; in_data = w[15:8];
        @(negedge clk); in_data = w[7:0];
        @(negedge clk); in_ena = 1'b0;
        if (expect_rx) begin
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endtask

    task automatic read_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); rd_req = 1'b1;
        end
        @(negedge clk); rd_req = 1'b0;
    endtask

    // Wait for target RX length with the engine idle for several cycles
    task automatic wait_quiet(input int target, input int budget, input string name);
        int q;
        bit expired;
        q = 0;
        expired = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((int'(len) == target) && !busy) q++; else q = 0;
            if (q >= 4) begin
                expired = 1'b0;
                break;
            end
        end
        check(name, expired, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ow [6];
        bit hit;
        ow = '{16'h1101, 16'h2202, 16'h3303, 16'h4404, 16'h5505, 16'h6606};
        n_rst = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_div = 4'd2; cs_sel = 2'd1;
        hold_cs = 1'b0; in_ena = 1'b0; in_data = '0; rd_req = 1'b0; mon_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 3'b111);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_len", len, 0);
        check("rst_have_msg", have_msg, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_tx_ovf", tx_overflow, 0);
        check("rst_rx_ovf", rx_overflow, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Four SPI modes, single word 0xA53C, d=2, cs_sel=1
        for (int m = 0; m < 4; m++) begin
            cpol = m[1];
            cpha = m[0];
            repeat (3) @(negedge clk);
            check("idle_sclk_pre", sclk, cpol);
            clr_mon();
            send_word(16'hA53C, 1'b1);
            wait_quiet(2, 400, "wait_mode");
            check("mode_mosi_word", mosi_cap, 16'hA53C);
            check("mode_rises", rises, 16);
            check("mode_samples", samp_n, 16);
            check("mode_idle_sclk", sclk, cpol);
            check("mode_cs1_len", cs1_max, 68);
            check("mode_cs1_pulses", cs1_pulses, 1);
            check("mode_other_cs", other_low, 0);
            check("mode_len", len, 2);
            check("mode_have_msg", have_msg, 1);
            read_bytes(2);
            check("mode_have_msg_drop", have_msg, 0);
            check("mode_len_zero", len, 0);
        end

        // Burst with CS held across three words
        cpol = 1'b0; cpha = 1'b0; hold_cs = 1'b1;
        clr_mon();
        send_word(16'hC001, 1'b1);
        send_word(16'hC002, 1'b1);
        send_word(16'hC003, 1'b1);
        wait_quiet(6, 800, "wait_hold");
        check("hold_pulses", cs1_pulses, 1);
        check("hold_cs_len", cs1_max, 204);
        read_bytes(6);

        // Burst without CS hold: three separate pulses
        hold_cs = 1'b0;
        clr_mon();
        send_word(16'hD001, 1'b1);
        send_word(16'hD002, 1'b1);
        send_word(16'hD003, 1'b1);
        wait_quiet(6, 800, "wait_nohold");
        check("nohold_pulses", cs1_pulses, 3);
        check("nohold_min_len", cs1_min, 68);
        check("nohold_max_len", cs1_max, 68);
        check("nohold_gap_ge2", gap_min >= 2, 1);
        read_bytes(6);

        // clk_div=0 acts as 1; cs_sel out of range asserts no cs
        clk_div = 4'd0; cs_sel = 2'd3;
        clr_mon();
        send_word(16'h960F, 1'b1);
        wait_quiet(2, 200, "wait_nocs");
        check("nocs_busy_cycles", busy_cyc, 35);
        check("nocs_other_cs", other_low, 0);
        check("nocs_cs1_pulses", cs1_pulses, 0);
        check("nocs_mosi_word", mosi_cap, 16'h960F);
        read_bytes(2);
        cs_sel = 2'd1;

        // Overflow: slow engine, six words into a 4-deep TX FIFO, 4-deep RX FIFO
        clk_div = 4'd15;
        for (int i = 0; i < 5; i++) send_word(ow[i], i < 4);
        check("ovf_in_ready_low", in_ready, 0);
        check("ovf_tx_not_yet", tx_overflow, 0);
        send_word(ow[5], 1'b0);
        check("ovf_tx_set", tx_overflow, 1);
        wait_quiet(8, 3500, "wait_ovf");
        check("ovf_rx_set", rx_overflow, 1);
        check("ovf_len_cap", len, 8);
        check("ovf_in_ready_back", in_ready, 1);
        read_bytes(8);
        check("ovf_len_drained", len, 0);

        // Reset in the middle of SHIFT
        clk_div = 4'd2;
        clr_mon();
        send_word(16'h1234, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rises >= 7) begin
                hit = 1'b1;
                break;
            end
        end
        check("rst_mid_reached", hit, 1);
        n_rst = 1'b0;
        #1;
        check("rst_mid_cs", cs, 3'b111);
        check("rst_mid_sclk", sclk, 0);
        check("rst_mid_len", len, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ovf", {tx_overflow, rx_overflow}, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        clr_mon();
        send_word(16'h5AC3, 1'b1);
        wait_quiet(2, 400, "wait_after_rst");
        check("post_rst_mosi", mosi_cap, 16'h5AC3);
        check("post_rst_cs_len", cs1_max, 68);
        read_bytes(2);

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
